// File: rtl/datapath_multi.sv
// Shift-and-add multiplier datapath: multiplicand, accumulator/multiplier shift register and bit counter.
// Define DATAPATH_MULTI_OVF_EN to add the registered Ovf output (product exceeds WIDTH bits).
module datapath_multi #(
  parameter int WIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Load,
  input  logic                 Ad,
  input  logic                 Sh,
  input  logic                 Done,
  input  logic [WIDTH-1:0]     Mcand,
  input  logic [WIDTH-1:0]     Mplier,
  output logic                 M,
  output logic                 K,
`ifdef DATAPATH_MULTI_OVF_EN
  output logic                 Ovf,
`endif
  output logic [2*WIDTH-1:0]   Product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   b;
  logic [2*WIDTH:0]   acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cntNext;

  // The carry of the add lands in acc[2W] and is pulled back into the product by the next shift.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b};
    cntNext = (cnt == CW'(WIDTH-1)) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      b   <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (Load) begin
      b   <= Mcand;
      acc <= {{(WIDTH+1){1'b0}}, Mplier};
      cnt <= '0;
    end else if (Ad && Sh) begin
      acc <= {1'b0, sum, acc[WIDTH-1:1]};
      cnt <= cntNext;
    end else if (Ad) begin
      acc <= {sum, acc[WIDTH-1:0]};
    end else if (Sh) begin
      acc <= {1'b0, acc[2*WIDTH:1]};
      cnt <= cntNext;
    end
  end

  // Done samples the accumulator as it stood before any same-cycle command.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Product <= '0;
    end else if (Done) begin
      Product <= acc[2*WIDTH-1:0];
    end
  end

`ifdef DATAPATH_MULTI_OVF_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Ovf <= 1'b0;
    end else if (Done) begin
      Ovf <= |acc[2*WIDTH-1:WIDTH];
    end
  end
`endif

  assign M = acc[0];
  assign K = (cnt == CW'(WIDTH-1));

endmodule

// File: doc/datapath_multi.md
# datapath_multi

Shift-and-add multiplier datapath driven by `Control_MULTI`. It holds the multiplicand, the accumulator/multiplier shift register and the bit counter. It executes the controller's `Load`/`Ad`/`Sh`/`Done` commands and returns the `M` (current multiplier bit) and `K` (last bit) status signals that the controller consumes. It sits beside `Control_MULTI` inside the multiplier unit of the MIPS CPU and produces the full-width product for the HI/LO registers.

## Interface
- `WIDTH`, default 32: operand width in bits; legal range WIDTH ≥ 2.
- `Clk` input 1: the single clock; all state updates on its rising edge.
- `Rst` input 1: synchronous, active-high reset.
- `Load` input 1: from the controller; captures the operands and clears the counter.
- `Ad` input 1: from the controller; adds the multiplicand into the accumulator upper half.
- `Sh` input 1: from the controller; shifts the accumulator right by 1 and advances the counter.
- `Done` input 1: from the controller; latches the product.
- `Mcand` input WIDTH: multiplicand, unsigned.
- `Mplier` input WIDTH: multiplier, unsigned.
- `M` output 1: `ACC[0]`, the current multiplier bit.
- `K` output 1: high when `cnt == WIDTH-1`.
- `Product` output 2*WIDTH: registered result.
- `Ovf` output 1: present only with `DATAPATH_MULTI_OVF_EN` (see Configuration).

## Operation
- Registers:
  - `B[WIDTH-1:0]`: multiplicand.
  - `ACC[2*WIDTH:0]`: bit 2W is the carry, `[2W-1:W]` is the partial product, `[W-1:0]` is the multiplier.
  - `cnt[$clog2(WIDTH)-1:0]`: bit counter.
  - `Product`: result register.
- Reset (`Rst`=1 at an edge):
  - `B`, `ACC`, `cnt`, `Product` and `Ovf` are cleared.
  - Therefore `M`=0 and `K`=0.
  - Reset overrides all commands, including one arriving mid-multiply.
- Command priority per edge, highest first: `Rst` > `Load` > (`Ad`/`Sh`). `Done` acts independently.
- `Load`:
  - `B` <= `Mcand`.
  - `ACC` <= {(WIDTH+1)'b0, `Mplier`}.
  - `cnt` <= 0.
  - Any `Ad`/`Sh` asserted in the same cycle is ignored.
- `Ad` only: `ACC[2W:W]` <= `ACC[2W-1:W]` + `B`, a (WIDTH+1)-bit sum with the carry going into bit 2W. `ACC[W-1:0]` is unchanged.
- `Sh` only:
  - `ACC` <= {1'b0, `ACC[2W:1]`}.
  - `cnt` <= `cnt`+1, wrapping modulo WIDTH, so a `Sh` at `cnt`=WIDTH-1 returns `cnt` to 0.
- `Ad` and `Sh` together: the add is applied first, then the shift, in one cycle. `ACC` <= {1'b0, sum[WIDTH:0], `ACC[W-1:1]`}, and `cnt` increments.
- `Done`:
  - `Product` <= `ACC[2W-1:0]`.
  - If `Done` coincides with `Ad`/`Sh`, the pre-update `ACC` is captured.
  - If `Done` coincides with `Load`, the old `ACC` is captured.
  - `Product` holds its value until the next `Done` or `Rst`.
- No command asserted: all registers hold.
- Arithmetic is unsigned. The carry bit is consumed by the following `Sh`. A full WIDTH-step run leaves `ACC[2W]`=0.

## Timing
- `M` and `K` are combinational decodes of registers. They are valid in the cycle following the edge that updated `ACC`/`cnt`, and they never depend combinationally on the command inputs.
- Register updates occur one edge after a command is sampled.
- `Product` is visible the cycle after the edge that sampled `Done`.
- Minimum multiply latency:
  - 1 `Load` cycle.
  - WIDTH `Sh` cycles, plus one `Ad` cycle per 1-bit when the controller issues `Ad` separately.
  - 1 `Done` cycle.
- `K` is high during the cycle in which the controller issues the final `Sh`, and it drops after that `Sh`.

## Configuration
- `DATAPATH_MULTI_OVF_EN` defined:
  - Adds registered output `Ovf`, updated on `Done` to the OR-reduction of `ACC[2W-1:W]`. It flags that the product does not fit in WIDTH bits.
  - `Ovf` is cleared on reset and holds between `Done`s.
- Not defined: the `Ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: drive `Rst`=1 for 5 edges with random commands -> `Product`=0, `M`=0, `K`=0; with the macro defined, `Ovf`=0.
- WIDTH=4, `Mcand`=13, `Mplier`=11: `Load`, then per bit `Ad` (if `M`) followed by `Sh` for 4 bits, then `Done` -> `M` sequence 1,1,0,1, `K` high only before the 4th `Sh`, `Product`=143 (0x8F), `Ovf`=1.
- WIDTH=4, the same operands using combined `Ad`+`Sh` cycles -> `Product`=143 after 4 shift cycles.
- WIDTH=32, `Mcand`=0xFFFFFFFF, `Mplier`=0xFFFFFFFF -> `Product`=0xFFFFFFFE00000001, with the carry exercised on every add. Then 3×5 -> `Product`=15, `Ovf`=0.
- `Load` asserted simultaneously with `Ad`+`Sh` mid-run -> `ACC` is reloaded, `cnt`=0, and the add/shift is ignored.
- `Rst` asserted after 2 of 4 shifts -> all registers are 0 the next cycle. A new `Load` then runs a full multiply correctly: 7×9 -> 63.
